// File: rtl/semi_auto_cmd_conditioner.sv
// Button/detector front-end for the semi-auto driving FSM.
// Debounces presses into held one-hot commands; re-times detectors.
module semi_auto_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_TIMEOUT    = 2_000_000,
  parameter int CNT_W           = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_go_raw,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic       front_raw,
  input  logic       back_raw,
  input  logic       left_raw,
  input  logic       right_raw,
  input  logic [1:0] fsm_state,
  output logic       go_straight_command,
  output logic       turn_left_command,
  output logic       turn_right_command,
  output logic       front_detector,
  output logic       back_detector,
  output logic       left_detector,
  output logic       right_detector,
  output logic       cmd_accepted,
  output logic       cmd_dropped
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_WREL = 2'd2;

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [6:0]       raw;
  logic [6:0]       s1;
  logic [6:0]       s2;
  logic [2:0]       lvl;
  logic [2:0]       lvl_q;
  logic [2:0]       press;
  logic [CNT_W-1:0] db_cnt [3];
  logic [1:0]       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [2:0]       cmd;

  assign raw = {right_raw, left_raw, back_raw, front_raw,
                btn_right_raw, btn_left_raw, btn_go_raw};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  assign front_detector = s2[3];
  assign back_detector  = s2[4];
  assign left_detector  = s2[5];
  assign right_detector = s2[6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl <= '0;
      for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (s2[b] != lvl[b]) begin
          if (db_cnt[b] == DB_LAST) begin
            lvl[b]    <= ~lvl[b];
            db_cnt[b] <= '0;
          end else begin
            db_cnt[b] <= db_cnt[b] + ONE;
          end
        end else begin
          db_cnt[b] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q <= '0;
      press <= '0;
    end else begin
      lvl_q <= lvl;
      press <= lvl & ~lvl_q;
    end
  end

  // Simultaneous presses are ambiguous, so they are discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      cmd          <= '0;
      cmd_accepted <= 1'b0;
      cmd_dropped  <= 1'b0;
    end else begin
      cmd_accepted <= 1'b0;
      cmd_dropped  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (press != 3'b000) begin
            if ($onehot(press) && fsm_state == 2'b00) begin
              cmd      <= press;
              hold_cnt <= '0;
              state    <= S_HOLD;
            end else begin
              cmd_dropped <= 1'b1;
              state       <= S_WREL;
            end
          end
        end
        S_HOLD: begin
          if (fsm_state != 2'b00) begin
            cmd          <= '0;
            cmd_accepted <= 1'b1;
            state        <= S_WREL;
          end else if (hold_cnt == HOLD_LAST) begin
            cmd         <= '0;
            cmd_dropped <= 1'b1;
            state       <= S_WREL;
          end else begin
            hold_cnt <= hold_cnt + ONE;
          end
        end
        S_WREL: begin
          if (lvl == 3'b000) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign go_straight_command = cmd[0];
  assign turn_left_command   = cmd[1];
  assign turn_right_command  = cmd[2];

endmodule

// File: tb/tb_semi_auto_cmd_conditioner.sv
// Random stimulus bench for semi_auto_cmd_conditioner.
// Compares every cycle against an event-level reference model.
module tb_semi_auto_cmd_conditioner;

  localparam int D = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_go_raw = 1'b0;
  logic       btn_left_raw = 1'b0;
  logic       btn_right_raw = 1'b0;
  logic       front_raw = 1'b0;
  logic       back_raw = 1'b0;
  logic       left_raw = 1'b0;
  logic       right_raw = 1'b0;
  logic [1:0] fsm_state = 2'b00;
  logic       go_straight_command;
  logic       turn_left_command;
  logic       turn_right_command;
  logic       front_detector;
  logic       back_detector;
  logic       left_detector;
  logic       right_detector;
  logic       cmd_accepted;
  logic       cmd_dropped;

  semi_auto_cmd_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_TIMEOUT(T),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_go_raw(btn_go_raw),
    .btn_left_raw(btn_left_raw),
    .btn_right_raw(btn_right_raw),
    .front_raw(front_raw),
    .back_raw(back_raw),
    .left_raw(left_raw),
    .right_raw(right_raw),
    .fsm_state(fsm_state),
    .go_straight_command(go_straight_command),
    .turn_left_command(turn_left_command),
    .turn_right_command(turn_right_command),
    .front_detector(front_detector),
    .back_detector(back_detector),
    .left_detector(left_detector),
    .right_detector(right_detector),
    .cmd_accepted(cmd_accepted),
    .cmd_dropped(cmd_dropped)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: raw history, stable-run debounce, event FSM.
  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_WAIT = 2;

  logic [6:0] pipe[$];
  logic [2:0] m_lvl;
  logic [2:0] m_lvl_prev;
  logic [2:0] m_press;
  int         m_run[3];
  int         m_mode;
  int         m_cmd;
  int         m_tl;
  int         cyc;
  logic       m_acc;
  logic       m_drp;
  int         n_acc = 0;
  int         n_drop = 0;

  logic [6:0] raw_now;
  assign raw_now = {right_raw, left_raw, back_raw, front_raw,
                    btn_right_raw, btn_left_raw, btn_go_raw};

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(7'd0);
    pipe.push_back(7'd0);
    m_lvl = '0;
    m_lvl_prev = '0;
    m_press = '0;
    for (int b = 0; b < 3; b++) m_run[b] = 0;
    m_mode = M_IDLE;
    m_cmd = -1;
    m_tl = 0;
    m_acc = 1'b0;
    m_drp = 1'b0;
  endtask

  task automatic model_step();
    logic [6:0] seen;
    logic [2:0] lvl_old;
    logic [2:0] press_old;
    int         n;
    seen      = pipe[0];
    lvl_old   = m_lvl;
    press_old = m_press;
    void'(pipe.pop_front());
    pipe.push_back(raw_now);
    for (int b = 0; b < 3; b++) begin
      if (seen[b] != m_lvl[b]) begin
        if (m_run[b] == D - 1) begin
          m_lvl[b] = ~m_lvl[b];
          m_run[b] = 0;
        end else begin
          m_run[b]++;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_press    = lvl_old & ~m_lvl_prev;
    m_lvl_prev = lvl_old;
    m_acc = 1'b0;
    m_drp = 1'b0;
    n = $countones(press_old);
    if (m_mode == M_IDLE) begin
      if (n == 1 && fsm_state == 2'b00) begin
        for (int b = 0; b < 3; b++) if (press_old[b]) m_cmd = b;
        m_tl = cyc;
        m_mode = M_HOLD;
      end else if (n >= 1) begin
        m_drp = 1'b1;
        m_mode = M_WAIT;
      end
    end else if (m_mode == M_HOLD) begin
      if (fsm_state != 2'b00) begin
        m_cmd = -1;
        m_acc = 1'b1;
        m_mode = M_WAIT;
      end else if (cyc - m_tl == T) begin
        m_cmd = -1;
        m_drp = 1'b1;
        m_mode = M_WAIT;
      end
    end else begin
      if (lvl_old == 3'b000) m_mode = M_IDLE;
    end
    if (m_acc) n_acc++;
    if (m_drp) n_drop++;
    cyc++;
  endtask

  function automatic logic [8:0] dut_all();
    return {turn_right_command, turn_left_command, go_straight_command,
            right_detector, left_detector, back_detector, front_detector,
            cmd_accepted, cmd_dropped};
  endfunction

  task automatic compare();
    logic [2:0] ecmd;
    ecmd = (m_cmd < 0) ? 3'b000 : 3'(1 << m_cmd);
    chk("cmd", 32'({turn_right_command, turn_left_command,
                    go_straight_command}), 32'(ecmd));
    chk("det", 32'({right_detector, left_detector, back_detector,
                    front_detector}), 32'(pipe[0][6:3]));
    chk("pulse", 32'({cmd_accepted, cmd_dropped}),
        32'({m_acc, m_drp}));
  endtask

  logic [2:0] tgt = '0;
  int         gl[3];
  int         phase = 0;
  int         n_rst = 0;

  task automatic drive();
    logic [2:0] b_raw;
    for (int b = 0; b < 3; b++) begin
      if ($urandom_range(0, tgt[b] ? 9 : 24) == 0) tgt[b] = ~tgt[b];
      if (gl[b] == 0 && $urandom_range(0, 11) == 0)
        gl[b] = $urandom_range(1, 3);
      b_raw[b] = tgt[b] ^ (gl[b] > 0);
      if (gl[b] > 0) gl[b]--;
    end
    btn_go_raw    = b_raw[0];
    btn_left_raw  = b_raw[1];
    btn_right_raw = b_raw[2];
    if ($urandom_range(0, 3) == 0) begin
      {right_raw, left_raw, back_raw, front_raw} =
        4'($urandom_range(0, 15));
    end else begin
      {right_raw, left_raw, back_raw, front_raw} =
        ~{right_raw, left_raw, back_raw, front_raw};
    end
    if (cyc % 300 == 0) phase = $urandom_range(0, 2);
    case (phase)
      0: fsm_state = 2'b00;
      1: if ($urandom_range(0, 5) == 0)
           fsm_state = 2'($urandom_range(0, 3));
      default: fsm_state = ($urandom_range(0, 7) == 0) ?
                 2'($urandom_range(1, 3)) : 2'b00;
    endcase
  endtask

  initial begin
    for (int b = 0; b < 3; b++) gl[b] = 0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_all", 32'(dut_all()), 32'd0);
    rst = 1'b1;
    for (int c = 0; c < 8000; c++) begin
      drive();
      @(posedge clk);
      model_step();
      if (m_mode == M_HOLD && n_rst < 6 &&
          $urandom_range(0, 29) == 0) begin
        #2 rst = 1'b0;
        #1 chk("arst", 32'(dut_all()), 32'd0);
        n_rst++;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
      compare();
    end
    chk("saw_accept", 32'(n_acc > 0), 32'd1);
    chk("saw_drop", 32'(n_drop > 0), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
